// File: rtl/sub_arbiter_ctrl_pkg.sv
// Shared definitions for the round-robin subtractor controller.
package sub_arb_pkg;

    // Default configuration
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;
    localparam int DEF_CNTW  = 16;

    // State encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_e;

endpackage

// File: rtl/sub_arbiter_ctrl_if.sv
// Request/response bundle between the arithmetic users and the controller.
// The master side drives operands; the slave side (controller) drives
// accepts, results and status.
interface sub_arbiter_ctrl_if
    import sub_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int CNTW  = DEF_CNTW
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_diff;
    logic                  rsp_borrow;
    logic                  busy;
    logic [CNTW-1:0]       op_count;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_diff, rsp_borrow, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_diff, rsp_borrow, busy, op_count
    );

endinterface

// File: rtl/sub_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// granted index and wraps, so the most recently served requester is
// considered last.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IDXW-1:0] o_grant_idx,
    output logic            o_any_grant
);

    logic            w_found;
    logic [IDXW-1:0] w_idx;

    // Walk the candidates in priority order and keep the first one requesting
    always_comb begin
        w_found     = 1'b0;
        w_idx       = '0;
        o_grant     = '0;
        o_grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDXW'((int'(i_last) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant_idx    = w_idx;
                o_grant[w_idx] = 1'b1;
            end
        end
        o_any_grant = w_found;
    end

endmodule

// File: rtl/sub_arbiter_ctrl.sv
// Shares one registered subtract-with-borrow unit between NREQ requesters.
// Flow per operation: IDLE (accept) -> EXEC (subtract) -> RESP (result pulse).
module sub_arbiter_ctrl
    import sub_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             rst,
    sub_arbiter_ctrl_if.slave bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            r_state;
    logic [IDXW-1:0]   r_last;
    logic [IDXW-1:0]   r_owner;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_diff;
    logic              r_rsp_borrow;
    logic              r_busy;
    logic [CNTW-1:0]   r_op_count;

    logic [NREQ-1:0]   w_grant;
    logic [IDXW-1:0]   w_grant_idx;
    logic              w_any_grant;
    logic              w_idle;
    logic              w_accept;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;
    logic [WIDTH:0]    w_diff_full;
    logic [NREQ-1:0]   w_owner_onehot;
    logic              w_cnt_sat;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .i_req       (bus.req_valid),
        .i_last      (r_last),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    assign w_idle   = (r_state == IDLE);
    // A grant only exists for an asserted request, so grant-in-IDLE is the
    // valid & ready handshake.
    assign w_accept = w_idle && w_any_grant;

    assign w_sel_a = bus.req_a[w_grant_idx*WIDTH +: WIDTH];
    assign w_sel_b = bus.req_b[w_grant_idx*WIDTH +: WIDTH];

    // Extra top bit of the widened subtraction is the borrow out.
    assign w_diff_full = {1'b0, r_a} - {1'b0, r_b};

    assign w_cnt_sat = &r_op_count;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner_dec
            assign w_owner_onehot[gi] = (r_owner == IDXW'(gi));
        end
    endgenerate

    assign bus.req_ready  = w_idle ? w_grant : '0;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_diff   = r_rsp_diff;
    assign bus.rsp_borrow = r_rsp_borrow;
    assign bus.busy       = r_busy;
    assign bus.op_count   = r_op_count;

    // Control FSM with operand capture, subtraction, response and counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last       <= IDXW'(NREQ - 1);
            r_owner      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp_valid  <= '0;
            r_rsp_diff   <= '0;
            r_rsp_borrow <= 1'b0;
            r_busy       <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_owner <= w_grant_idx;
                        r_last  <= w_grant_idx;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // Result and pulse are registered here so they appear
                    // together during RESP; the count tracks that pulse.
                    {r_rsp_borrow, r_rsp_diff} <= w_diff_full;
                    r_rsp_valid <= w_owner_onehot;
                    if (!w_cnt_sat) begin
                        r_op_count <= r_op_count + CNTW'(1);
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
